rv_csr_m: RTL and testbench
===========================

# rv_csr_m

Parametrised machine-mode Control and Status Register file for the dv-cpu-rv core. It supports RV32 and RV64 through one parameter. It holds the M-mode trap-setup, trap-handling, information and counter CSRs, executes Zicsr read/write/set/clear accesses from the execute stage, and performs trap entry and `mret` state updates. It also produces the interrupt request and the redirect PCs consumed by the fetch/pipeline control logic.

## Interface
Parameters:
- `XLEN`, 32: register width; only 32 and 64 are legal. When 32, the `*h` counter aliases exist.
- `HARTID`, 0: value of `mhartid`.
- `VENDORID`, 0: value of `mvendorid`.
- `ARCHID`, 0: value of `marchid`.
- `IMPID`, 0: value of `mimpid`.
- `MTVEC_RST`, 0: reset value of `mtvec`; bit 1 is forced to 0.
- `ISA_M`, 1: value of `misa` bit 12 (M).
- `ISA_F`, 0: value of `misa` bit 5 (F).

Ports:
- `clk` in 1: the single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `csr_valid` in 1: CSR access this cycle.
- `csr_op` in 2: 01 RW, 10 RS, 11 RC; 00 is a read with no write.
- `csr_addr` in 12: CSR address.
- `csr_wdata` in XLEN: rs1 value or zero-extended immediate.
- `csr_rdata` out XLEN: old CSR value, combinational.
- `csr_illegal` out 1: access is illegal, combinational.
- `trap_valid` in 1: take a trap this cycle.
- `trap_cause` in XLEN: cause; the MSB is set for interrupts.
- `trap_pc` in XLEN: PC of the faulting instruction, or the next PC for interrupts.
- `trap_val` in XLEN: value for `mtval`.
- `trap_target` out XLEN: trap handler address, combinational.
- `mret_valid` in 1: `mret` executed.
- `mret_target` out XLEN: current `mepc`.
- `retire` in 1: one instruction retired.
- `irq_ext` in 1: external interrupt line, level.
- `irq_timer` in 1: timer interrupt line, level.
- `irq_sw` in 1: software interrupt line, level.
- `irq_req` out 1: registered interrupt request.
- `irq_cause` out XLEN: registered cause for `irq_req`.

## Operation
- Address map:
  - 300 `mstatus`, 301 `misa`, 304 `mie`, 305 `mtvec`, 320 `mcountinhibit`.
  - 340 `mscratch`, 341 `mepc`, 342 `mcause`, 343 `mtval`, 344 `mip`.
  - B00 `mcycle`, B02 `minstret`; B80 `mcycleh` and B82 `minstreth` exist only when XLEN=32.
  - F11–F14 vendor/arch/imp/hart ID.
- Write value per op:
  - RW: `wdata`.
  - RS: `old | wdata`.
  - RC: `old & ~wdata`.
  - RS/RC with `csr_wdata==0` perform no write. Op 00 performs no write.
- `csr_illegal` is asserted when either:
  - the address is unmapped, or
  - the access writes and `csr_addr[11:10]==2'b11` (read-only space).
- An illegal access changes no state.
- `misa` is fixed:
  - MXL = 01 for XLEN=32, 10 for XLEN=64.
  - I bit = 1; M and F bits come from parameters; all other bits are 0.
  - Writes are silently ignored and are not illegal.
- `mstatus`:
  - Writable bits: MIE[3], MPIE[7].
  - MPP[12:11] always reads 11.
  - All other bits read 0.
- `mie`: writable bits MEIE[11], MTIE[7], MSIE[3]; all other bits read 0.
- `mip`: read-only.
  - MEIP = `irq_ext`, MTIP = `irq_timer`, MSIP = `irq_sw`.
  - Writes are ignored and are not illegal.
- `mtvec`:
  - BASE = bits [XLEN-1:2]; MODE = bit 0.
  - Bit 1 always reads 0.
- `mepc`: bits [1:0] always written 0.
- `mcountinhibit`: bit 0 (CY) and bit 2 (IR) are writable; all other bits read 0.
- Counters are 64 bits wide:
  - `mcycle` increments every cycle unless CY=1.
  - `minstret` increments on `retire` unless IR=1.
  - Wrap from all-ones to 0.
  - A CSR write to any counter half in the same cycle overrides that cycle's increment of the whole counter; the other half holds.
- Trap entry (`trap_valid`) updates state:
  - `mepc` ← `trap_pc & ~3`, `mcause` ← `trap_cause`, `mtval` ← `trap_val`.
  - MPIE ← MIE, MIE ← 0.
- `trap_target`:
  - MODE=1 and `trap_cause` MSB set: BASE·4 + 4·`trap_cause[XLEN-2:0]`.
  - Otherwise: BASE·4.
- `mret_valid`: MIE ← MPIE, MPIE ← 1.
- Priority when events coincide: `trap_valid` > `mret_valid` > CSR write.
  - A lower-priority event's state change is dropped.
  - Counters still advance.
- Interrupt request:
  - `irq_req` = MIE & |(mip & mie).
  - `irq_cause` = MSB set, with code chosen by priority 11 (MEI) > 3 (MSI) > 7 (MTI).

## Timing
- `csr_rdata`, `csr_illegal`, `trap_target` and `mret_target` are combinational from current state.
- A read in the same cycle as a write returns the old value.
- All state updates occur on the rising edge of `clk`, so new values are visible the following cycle.
- `irq_req` and `irq_cause` are registered: a change in inputs or enables appears one cycle later.
- `irq_req` falls the cycle after a trap clears MIE.
- Reset (`rstn=0`, asynchronous, effective mid-operation):
  - `mstatus` MIE=MPIE=0; `mie`=0; `mtvec`=MTVEC_RST.
  - `mepc`=`mcause`=`mtval`=`mscratch`=0; `mcountinhibit`=0.
  - Both counters = 0.
  - `irq_req`=0, `irq_cause`=0.
- Combinational outputs reflect reset state: `mret_target`=0, and `trap_target` follows MTVEC_RST.

## Test plan
- Reset, then read 301 with XLEN=32, ISA_M=1 → `csr_rdata`=0x40001100. Read 300 → 0x00001800. Read F14 → HARTID.
- RW 305←0x80000001; then trap with cause 0x80000007 → `trap_target`=0x8000001C. Trap with cause 2 → 0x80000000, `mepc`=`trap_pc`&~3.
- Set MIE and MTIE, raise `irq_timer` together with `irq_ext` and MEIE → `irq_req`=1 one cycle later, `irq_cause`=0x8000000B. Trap → MIE=0, MPIE=1. `mret` → MIE=1.
- RS 304 with `wdata`=0 → no write, not illegal. RW to F11 → `csr_illegal`=1, no state change. Read 7C0 → illegal.
- Preload `mcycle`=0xFFFFFFFF (XLEN=32) → next cycle `mcycle`=0, `mcycleh`=1. Write IR=1 with `retire` held high → `minstret` frozen.
- Assert `trap_valid`, `mret_valid` and an RW to 341 in the same cycle → `mepc`=`trap_pc`&~3 and MIE=0, with the `mret` and the write both discarded.

Source files
------------

// File: rtl/rv_csr_m.sv
// Machine-mode CSR file for RV32/RV64: Zicsr accesses, trap entry / mret sequencing,
// 64-bit mcycle/minstret counters and a registered interrupt request.
module rv_csr_m #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] HARTID    = '0,
    parameter logic [XLEN-1:0] VENDORID  = '0,
    parameter logic [XLEN-1:0] ARCHID    = '0,
    parameter logic [XLEN-1:0] IMPID     = '0,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter bit              ISA_M     = 1'b1,
    parameter bit              ISA_F     = 1'b0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_val,
    output logic [XLEN-1:0] trap_target,
    input  logic            mret_valid,
    output logic [XLEN-1:0] mret_target,
    input  logic            retire,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause
);

    localparam bit              RV32       = (XLEN == 32);
    localparam logic [XLEN-1:0] MTVEC_INIT = MTVEC_RST & ~XLEN'(2);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MCOUNTINH = 12'h320;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic            meie_q, meie_d, mtie_q, mtie_d, msie_q, msie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic            cy_inh_q, cy_inh_d, ir_inh_q, ir_inh_d;
    logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic            irq_req_q, irq_req_d;
    logic [XLEN-1:0] irq_cause_q, irq_cause_d;

    logic [XLEN-1:0] mstatus_v, mie_v, mip_v, misa_v, old_v, wval, tvec_base;
    logic            mapped, wr_req, wr_en;

    always_comb begin
        mstatus_v                    = '0;
        mstatus_v[12:11]             = 2'b11;
        mstatus_v[7]                 = mpie_q;
        mstatus_v[3]                 = mie_q;
        mie_v                        = '0;
        mie_v[11]                    = meie_q;
        mie_v[7]                     = mtie_q;
        mie_v[3]                     = msie_q;
        mip_v                        = '0;
        mip_v[11]                    = irq_ext;
        mip_v[7]                     = irq_timer;
        mip_v[3]                     = irq_sw;
        misa_v                       = '0;
        misa_v[XLEN-1:XLEN-2]        = RV32 ? 2'b01 : 2'b10;
        misa_v[12]                   = ISA_M;
        misa_v[8]                    = 1'b1;
        misa_v[5]                    = ISA_F;
    end

    // Read mux doubles as the address decoder; the *h aliases only decode on RV32.
    always_comb begin
        old_v  = '0;
        mapped = 1'b1;
        case (csr_addr)
            A_MSTATUS:   old_v = mstatus_v;
            A_MISA:      old_v = misa_v;
            A_MIE:       old_v = mie_v;
            A_MTVEC:     old_v = mtvec_q;
            A_MCOUNTINH: begin
                old_v[2] = ir_inh_q;
                old_v[0] = cy_inh_q;
            end
            A_MSCRATCH:  old_v = mscratch_q;
            A_MEPC:      old_v = mepc_q;
            A_MCAUSE:    old_v = mcause_q;
            A_MTVAL:     old_v = mtval_q;
            A_MIP:       old_v = mip_v;
            A_MCYCLE:    old_v = mcycle_q[XLEN-1:0];
            A_MINSTRET:  old_v = minstret_q[XLEN-1:0];
            A_MCYCLEH: begin
                if (RV32) old_v = mcycle_q[63:64-XLEN];
                else      mapped = 1'b0;
            end
            A_MINSTRETH: begin
                if (RV32) old_v = minstret_q[63:64-XLEN];
                else      mapped = 1'b0;
            end
            A_MVENDORID: old_v = VENDORID;
            A_MARCHID:   old_v = ARCHID;
            A_MIMPID:    old_v = IMPID;
            A_MHARTID:   old_v = HARTID;
            default:     mapped = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b10:   wval = old_v | csr_wdata;
            2'b11:   wval = old_v & ~csr_wdata;
            default: wval = csr_wdata;
        endcase
    end

    assign wr_req      = csr_valid && ((csr_op == 2'b01) || (csr_op[1] && (|csr_wdata)));
    assign csr_illegal = csr_valid && (!mapped || (wr_req && (csr_addr[11:10] == 2'b11)));
    assign wr_en       = wr_req && !csr_illegal && !trap_valid && !mret_valid;

    assign csr_rdata   = old_v;
    assign mret_target = mepc_q;
    assign tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_target = (mtvec_q[0] && trap_cause[XLEN-1])
                       ? tvec_base + {trap_cause[XLEN-3:0], 2'b00}
                       : tvec_base;

    // Trap beats mret beats a CSR write; counters advance regardless.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        meie_d     = meie_q;
        mtie_d     = mtie_q;
        msie_d     = msie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        cy_inh_d   = cy_inh_q;
        ir_inh_d   = ir_inh_q;
        mcycle_d   = cy_inh_q ? mcycle_q : mcycle_q + 64'd1;
        minstret_d = (retire && !ir_inh_q) ? minstret_q + 64'd1 : minstret_q;
        if (trap_valid) begin
            mepc_d   = trap_pc & ~XLEN'(3);
            mcause_d = trap_cause;
            mtval_d  = trap_val;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_valid) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mie_d  = wval[3];
                    mpie_d = wval[7];
                end
                A_MIE: begin
                    meie_d = wval[11];
                    mtie_d = wval[7];
                    msie_d = wval[3];
                end
                A_MTVEC:     mtvec_d = {wval[XLEN-1:2], 1'b0, wval[0]};
                A_MCOUNTINH: begin
                    cy_inh_d = wval[0];
                    ir_inh_d = wval[2];
                end
                A_MSCRATCH:  mscratch_d = wval;
                A_MEPC:      mepc_d = wval & ~XLEN'(3);
                A_MCAUSE:    mcause_d = wval;
                A_MTVAL:     mtval_d = wval;
                A_MCYCLE: begin
                    if (RV32) mcycle_d = {mcycle_q[63:32], wval[31:0]};
                    else      mcycle_d = 64'(wval);
                end
                A_MINSTRET: begin
                    if (RV32) minstret_d = {minstret_q[63:32], wval[31:0]};
                    else      minstret_d = 64'(wval);
                end
                A_MCYCLEH:   mcycle_d = {wval[31:0], mcycle_q[31:0]};
                A_MINSTRETH: minstret_d = {wval[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    // Pending-and-enabled set, priority MEI > MSI > MTI.
    always_comb begin
        irq_req_d   = mie_q && ((irq_ext && meie_q) || (irq_sw && msie_q) || (irq_timer && mtie_q));
        irq_cause_d = '0;
        if (irq_ext && meie_q)        irq_cause_d = {1'b1, (XLEN-1)'(11)};
        else if (irq_sw && msie_q)    irq_cause_d = {1'b1, (XLEN-1)'(3)};
        else if (irq_timer && mtie_q) irq_cause_d = {1'b1, (XLEN-1)'(7)};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            meie_q      <= 1'b0;
            mtie_q      <= 1'b0;
            msie_q      <= 1'b0;
            mtvec_q     <= MTVEC_INIT;
            mscratch_q  <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            cy_inh_q    <= 1'b0;
            ir_inh_q    <= 1'b0;
            mcycle_q    <= '0;
            minstret_q  <= '0;
            irq_req_q   <= 1'b0;
            irq_cause_q <= '0;
        end else begin
            mie_q       <= mie_d;
            mpie_q      <= mpie_d;
            meie_q      <= meie_d;
            mtie_q      <= mtie_d;
            msie_q      <= msie_d;
            mtvec_q     <= mtvec_d;
            mscratch_q  <= mscratch_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            cy_inh_q    <= cy_inh_d;
            ir_inh_q    <= ir_inh_d;
            mcycle_q    <= mcycle_d;
            minstret_q  <= minstret_d;
            irq_req_q   <= irq_req_d;
            irq_cause_q <= irq_cause_d;
        end
    end

    assign irq_req   = irq_req_q;
    assign irq_cause = irq_cause_q;

endmodule

// File: tb/tb_rv_csr_m.sv
// Directed bench for rv_csr_m (XLEN=32): driver queues expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rv_csr_m;

    localparam int S_RD = 0, S_ILL = 1, S_TT = 2, S_MT = 3, S_IRQ = 4, S_CAUSE = 5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause, trap_pc, trap_val, trap_target;
    logic        mret_valid;
    logic [31:0] mret_target;
    logic        retire, irq_ext, irq_timer, irq_sw, irq_req;
    logic [31:0] irq_cause;

    rv_csr_m #(
        .XLEN(32), .HARTID(32'd5), .VENDORID(32'd0), .ARCHID(32'd0), .IMPID(32'd0),
        .MTVEC_RST(32'h0000_0106), .ISA_M(1'b1), .ISA_F(1'b0)
    ) dut (
        .clk(clk), .rstn(rstn),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
        .trap_target(trap_target), .mret_valid(mret_valid), .mret_target(mret_target),
        .retire(retire), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
        .irq_req(irq_req), .irq_cause(irq_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            case (e.sel)
                S_RD:    act = csr_rdata;
                S_ILL:   act = {31'd0, csr_illegal};
                S_TT:    act = trap_target;
                S_MT:    act = mret_target;
                S_IRQ:   act = {31'd0, irq_req};
                default: act = irq_cause;
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.exp);
            end
        end
    end

    task automatic chk(input int sel, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.exp  = v;
        e.name = n;
        sbq.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        csr_valid  = 1'b0;
        csr_op     = 2'b00;
        csr_addr   = 12'h000;
        csr_wdata  = '0;
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        retire     = 1'b0;
    endtask

    task automatic acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = wd;
    endtask

    task automatic trap(input logic [31:0] c, input logic [31:0] pc, input logic [31:0] v);
        trap_valid = 1'b1;
        trap_cause = c;
        trap_pc    = pc;
        trap_val   = v;
    endtask

    initial begin
        rstn = 1'b0;
        csr_valid = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
        trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_val = '0;
        mret_valid = 1'b0; retire = 1'b0;
        irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;
        nxt(); nxt();
        acc(2'b00, 12'h341, 0);
        chk(S_RD, 32'h0, "rst_mepc"); chk(S_TT, 32'h104, "rst_ttgt");
        chk(S_MT, 32'h0, "rst_mret"); chk(S_IRQ, 32'h0, "rst_irq"); chk(S_CAUSE, 32'h0, "rst_cause");
        nxt(); rstn = 1'b1;

        nxt(); acc(2'b00, 12'h301, 0); chk(S_RD, 32'h4000_1100, "misa"); chk(S_ILL, 0, "misa_ill");
        nxt(); acc(2'b00, 12'h300, 0); chk(S_RD, 32'h0000_1800, "mstatus_rst");
        nxt(); acc(2'b00, 12'hF14, 0); chk(S_RD, 32'd5, "mhartid");
        nxt(); acc(2'b01, 12'h305, 32'h8000_0001); chk(S_RD, 32'h104, "mtvec_old");
        nxt(); acc(2'b00, 12'h305, 0); chk(S_RD, 32'h8000_0001, "mtvec_new");
        trap(32'h8000_0007, 32'h1237, 32'hDEAD); chk(S_TT, 32'h8000_001C, "tt_vec");
        nxt(); acc(2'b00, 12'h341, 0); chk(S_RD, 32'h1234, "mepc_t1");
        trap(32'h2, 32'h2002, 32'hBEEF); chk(S_TT, 32'h8000_0000, "tt_exc");
        nxt(); acc(2'b00, 12'h342, 0); chk(S_RD, 32'h2, "mcause_t2");
        nxt(); acc(2'b00, 12'h343, 0); chk(S_RD, 32'hBEEF, "mtval_t2");

        nxt(); acc(2'b01, 12'h300, 32'h8);
        nxt(); acc(2'b01, 12'h304, 32'h880); irq_timer = 1'b1; irq_ext = 1'b1;
        nxt(); acc(2'b00, 12'h344, 0); chk(S_RD, 32'h880, "mip"); chk(S_IRQ, 0, "irq_lat");
        nxt(); chk(S_IRQ, 1, "irq_on"); chk(S_CAUSE, 32'h8000_000B, "cause_mei");
        trap(32'h8000_000B, 32'h3000, 0); chk(S_TT, 32'h8000_002C, "tt_mei");
        nxt(); acc(2'b00, 12'h300, 0); chk(S_RD, 32'h1880, "mstatus_trap"); chk(S_IRQ, 1, "irq_hold");
        nxt(); chk(S_IRQ, 0, "irq_off_trap"); mret_valid = 1'b1; chk(S_MT, 32'h3000, "mret_tgt");
        nxt(); acc(2'b00, 12'h300, 0); chk(S_RD, 32'h1888, "mstatus_mret"); chk(S_IRQ, 0, "irq_mret_lat");
        nxt(); chk(S_IRQ, 1, "irq_back"); chk(S_CAUSE, 32'h8000_000B, "cause_mei2"); irq_ext = 1'b0;
        nxt(); chk(S_CAUSE, 32'h8000_0007, "cause_mti"); acc(2'b10, 12'h304, 32'h8); irq_sw = 1'b1;
        nxt(); chk(S_CAUSE, 32'h8000_0007, "cause_msi_lat");
        nxt(); chk(S_CAUSE, 32'h8000_0003, "cause_msi"); irq_sw = 1'b0; irq_timer = 1'b0;
        nxt(); chk(S_IRQ, 0, "irq_lines_low");
        acc(2'b10, 12'h304, 32'h0); chk(S_ILL, 0, "rs0_ill"); chk(S_RD, 32'h888, "mie_old");
        nxt(); acc(2'b00, 12'h304, 0); chk(S_RD, 32'h888, "mie_kept");
        nxt(); acc(2'b01, 12'hF11, 32'h1); chk(S_ILL, 1, "ro_write_ill");
        nxt(); acc(2'b00, 12'h7C0, 0); chk(S_ILL, 1, "unmapped_ill"); chk(S_RD, 0, "unmapped_rd");
        nxt(); acc(2'b10, 12'hF11, 32'h0); chk(S_ILL, 0, "ro_rs0_ok");

        nxt(); acc(2'b01, 12'h340, 32'hA5A5_A5A5);
        nxt(); acc(2'b11, 12'h340, 32'hFF); chk(S_RD, 32'hA5A5_A5A5, "mscratch_rw");
        nxt(); acc(2'b10, 12'h340, 32'h0F); chk(S_RD, 32'hA5A5_A500, "mscratch_rc");
        nxt(); acc(2'b00, 12'h340, 0); chk(S_RD, 32'hA5A5_A50F, "mscratch_rs");
        nxt(); acc(2'b01, 12'h341, 32'h123);
        nxt(); acc(2'b00, 12'h341, 0); chk(S_RD, 32'h120, "mepc_align");
        nxt(); acc(2'b01, 12'h305, 32'h7);
        nxt(); acc(2'b00, 12'h305, 0); chk(S_RD, 32'h5, "mtvec_bit1");
        trap_cause = 32'h8000_0002; chk(S_TT, 32'hC, "tt_vec2");

        nxt(); acc(2'b01, 12'h320, 32'h5);
        nxt(); acc(2'b01, 12'hB00, 32'hFFFF_FFFF);
        nxt(); acc(2'b01, 12'hB80, 32'h0);
        nxt(); acc(2'b01, 12'h320, 32'h0); chk(S_RD, 32'h5, "mcountinhibit");
        nxt(); acc(2'b00, 12'hB00, 0); chk(S_RD, 32'hFFFF_FFFF, "mcycle_pre");
        nxt(); acc(2'b00, 12'hB80, 0); chk(S_RD, 32'h1, "mcycleh_carry");
        nxt(); acc(2'b00, 12'hB00, 0); chk(S_RD, 32'h1, "mcycle_wrap");
        nxt(); acc(2'b01, 12'hB02, 32'd10); retire = 1'b1;
        nxt(); acc(2'b00, 12'hB02, 0); retire = 1'b1; chk(S_RD, 32'd10, "minstret_wr");
        nxt(); acc(2'b01, 12'h320, 32'h4); retire = 1'b1;
        nxt(); acc(2'b00, 12'hB02, 0); retire = 1'b1; chk(S_RD, 32'd12, "minstret_inc");
        nxt(); acc(2'b00, 12'hB02, 0); retire = 1'b1; chk(S_RD, 32'd12, "minstret_frozen");

        nxt(); acc(2'b01, 12'h300, 32'h8);
        nxt(); acc(2'b01, 12'h341, 32'h5554); trap(32'h3, 32'h4446, 32'h0); mret_valid = 1'b1;
        nxt(); acc(2'b00, 12'h341, 0); chk(S_RD, 32'h4444, "prio_mepc");
        nxt(); acc(2'b00, 12'h300, 0); chk(S_RD, 32'h1880, "prio_mstatus");
        nxt(); acc(2'b00, 12'h342, 0); chk(S_RD, 32'h3, "prio_mcause");

        nxt(); acc(2'b00, 12'h341, 0);
        #2 rstn = 1'b0;
        chk(S_RD, 32'h0, "async_mepc"); chk(S_TT, 32'h104, "async_ttgt");
        chk(S_MT, 32'h0, "async_mret"); chk(S_IRQ, 32'h0, "async_irq");
        nxt(); nxt();

        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
